// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the bit-serial datapath blocks.
//   state_t  : sequencer state encoding shared by the serial blocks
//   MODE_*   : operation select values for the add/subtract mode input
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// full_adder
// Single-bit full adder used as the bit slice of the serial datapath.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial adder/subtractor with a start/done sequencer. Operands are
// captured on an accepted start and processed LSB-first, one bit per clock,
// through a single full adder and a carry flop.
//   clk, reset     : clock and synchronous active-high reset
//   start          : begin an operation (accepted only while ready)
//   sub            : 0 = a+b, 1 = a-b (sampled with start)
//   a, b           : operands (sampled with start)
//   ready          : idle, start will be accepted
//   busy           : serial operation in progress
//   done           : one-cycle pulse, results valid
//   sum, cout, ovf : result, carry/no-borrow, signed overflow
module serial_addsub
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] b_load;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;

    // Subtraction is a + ~b + 1: invert B on load, the +1 comes from the
    // carry flop being preset to the mode bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bload
            assign b_load[gi] = (sub == MODE_SUB) ? ~b[gi] : b[gi];
        end
    endgenerate

    full_adder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign accept   = (state_reg == ST_IDLE) && start;
    assign last_bit = (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start)    state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b_load;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= sub;
        end else if (state_reg == ST_SHIFT) begin
            // Result bits enter at the MSB so that after WIDTH shifts the
            // first (LSB) result bit has arrived at bit 0.
            sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            carry_reg <= fa_c;
            if (last_bit) begin
                cout_reg <= fa_c;
                // carry_reg is the carry into the MSB on this cycle
                ovf_reg  <= carry_reg ^ fa_c;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign ready = (state_reg == ST_IDLE);
    assign busy  = (state_reg == ST_SHIFT);
    assign done  = (state_reg == ST_DONE);
    assign sum   = sum_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;

endmodule
